// File: rtl/video_mono_filter.sv
// Pixel-pipelined colour/monochrome output stage: BT.709 luma, per-mode tinting, scanline
// dimming and blank forcing, with mode/scanline changes latched on the vblank rising edge.
module video_mono_filter #(
    parameter int unsigned CW    = 6,
    parameter int unsigned OUT_W = 6
) (
    input  logic             clk_vga,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [1:0]       mode_req,
    input  logic             scanline_req,
    input  logic [CW-1:0]    r_in,
    input  logic [CW-1:0]    g_in,
    input  logic [CW-1:0]    b_in,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic             hb_in,
    input  logic             vb_in,
    output logic [OUT_W-1:0] r_out,
    output logic [OUT_W-1:0] g_out,
    output logic [OUT_W-1:0] b_out,
    output logic             hs_out,
    output logic             vs_out,
    output logic             hb_out,
    output logic             vb_out,
    output logic [1:0]       mode_active,
    output logic             scan_active
);

    localparam int unsigned SW = CW + 9;

    typedef enum logic [1:0] {
        ModeColour = 2'd0,
        ModeGreen  = 2'd1,
        ModeAmber  = 2'd2,
        ModeWhite  = 2'd3
    } mode_e;

    // Frame-level state
    logic          vb_prev_q, hb_prev_q;
    logic          line_odd_q, line_odd_d;
    logic [1:0]    mode_q;
    logic          scan_q;
    logic          vb_rise, hb_rise;

    // Stage 1
    logic [CW-1:0] r1_q, g1_q, b1_q;
    logic [3:0]    sync1_q;
    logic [1:0]    mode1_q;
    logic          scan1_q, odd1_q;

    // Stage 2
    logic [CW-1:0] r2_q, g2_q, b2_q;
    logic [SW-1:0] sum2_q, sum_d;
    logic [3:0]    sync2_q;
    logic [1:0]    mode2_q;
    logic          dim2_q;

    // Stage 3
    logic [OUT_W-1:0] r3_q, g3_q, b3_q;
    logic [OUT_W-1:0] r3_d, g3_d, b3_d;
    logic [3:0]       sync3_q;

    logic [CW-1:0] y, pr, pg, pb;

    assign vb_rise = vb_in & ~vb_prev_q;
    assign hb_rise = hb_in & ~hb_prev_q;

    always_comb begin
        line_odd_d = line_odd_q;
        if (vb_rise) begin
            line_odd_d = 1'b0;
        end else if (hb_rise) begin
            line_odd_d = ~line_odd_q;
        end
    end

    assign sum_d = SW'(r1_q) * SW'(54) + SW'(g1_q) * SW'(183) + SW'(b1_q) * SW'(19) + SW'(128);

    always_comb begin
        y  = CW'(sum2_q >> 8);
        pr = r2_q;
        pg = g2_q;
        pb = b2_q;
        unique case (mode_e'(mode2_q))
            ModeColour: begin
                pr = r2_q;
                pg = g2_q;
                pb = b2_q;
            end
            ModeGreen: begin
                pr = '0;
                pg = y;
                pb = '0;
            end
            ModeAmber: begin
                pr = y;
                pg = y >> 1;
                pb = '0;
            end
            ModeWhite: begin
                pr = y;
                pg = y;
                pb = y;
            end
        endcase
        if (dim2_q) begin
            pr = pr >> 1;
            pg = pg >> 1;
            pb = pb >> 1;
        end
        // sync2_q = {hs, vs, hb, vb}
        if (sync2_q[1] | sync2_q[0]) begin
            pr = '0;
            pg = '0;
            pb = '0;
        end
        r3_d = pr[CW-1 -: OUT_W];
        g3_d = pg[CW-1 -: OUT_W];
        b3_d = pb[CW-1 -: OUT_W];
    end

    always_ff @(posedge clk_vga) begin
        if (reset) begin
            vb_prev_q  <= 1'b0;
            hb_prev_q  <= 1'b0;
            line_odd_q <= 1'b0;
            mode_q     <= 2'd0;
            scan_q     <= 1'b0;
            r1_q       <= '0;
            g1_q       <= '0;
            b1_q       <= '0;
            sync1_q    <= '0;
            mode1_q    <= 2'd0;
            scan1_q    <= 1'b0;
            odd1_q     <= 1'b0;
            r2_q       <= '0;
            g2_q       <= '0;
            b2_q       <= '0;
            sum2_q     <= '0;
            sync2_q    <= '0;
            mode2_q    <= 2'd0;
            dim2_q     <= 1'b0;
            r3_q       <= '0;
            g3_q       <= '0;
            b3_q       <= '0;
            sync3_q    <= '0;
        end else if (ce_pix) begin
            vb_prev_q  <= vb_in;
            hb_prev_q  <= hb_in;
            line_odd_q <= line_odd_d;
            if (vb_rise) begin
                mode_q <= mode_req;
                scan_q <= scanline_req;
            end
            // S1 sees the pre-update frame state, so a new mode starts on the next strobe
            r1_q    <= r_in;
            g1_q    <= g_in;
            b1_q    <= b_in;
            sync1_q <= {hs_in, vs_in, hb_in, vb_in};
            mode1_q <= mode_q;
            scan1_q <= scan_q;
            odd1_q  <= line_odd_q;
            r2_q    <= r1_q;
            g2_q    <= g1_q;
            b2_q    <= b1_q;
            sum2_q  <= sum_d;
            sync2_q <= sync1_q;
            mode2_q <= mode1_q;
            dim2_q  <= scan1_q & odd1_q;
            r3_q    <= r3_d;
            g3_q    <= g3_d;
            b3_q    <= b3_d;
            sync3_q <= sync2_q;
        end
    end

    assign r_out       = r3_q;
    assign g_out       = g3_q;
    assign b_out       = b3_q;
    assign hs_out      = sync3_q[3];
    assign vs_out      = sync3_q[2];
    assign hb_out      = sync3_q[1];
    assign vb_out      = sync3_q[0];
    assign mode_active = mode_q;
    assign scan_active = scan_q;

endmodule

// File: tb/tb_video_mono_filter.sv
// Directed bench for video_mono_filter: latency, mode mux, frame-latched switching,
// scanline parity and ce_pix gating, all against hand-computed values.
module tb_video_mono_filter;

    logic       clk_vga = 1'b0;
    logic       reset, ce_pix;
    logic [1:0] mode_req;
    logic       scanline_req;
    logic [5:0] r_in, g_in, b_in;
    logic       hs_in, vs_in, hb_in, vb_in;
    logic [5:0] r_out, g_out, b_out;
    logic       hs_out, vs_out, hb_out, vb_out;
    logic [1:0] mode_active;
    logic       scan_active;

    int n_checks = 0;
    int n_errors = 0;

    video_mono_filter #(.CW(6), .OUT_W(6)) dut (
        .clk_vga      (clk_vga),
        .reset        (reset),
        .ce_pix       (ce_pix),
        .mode_req     (mode_req),
        .scanline_req (scanline_req),
        .r_in         (r_in),
        .g_in         (g_in),
        .b_in         (b_in),
        .hs_in        (hs_in),
        .vs_in        (vs_in),
        .hb_in        (hb_in),
        .vb_in        (vb_in),
        .r_out        (r_out),
        .g_out        (g_out),
        .b_out        (b_out),
        .hs_out       (hs_out),
        .vs_out       (vs_out),
        .hb_out       (hb_out),
        .vb_out       (vb_out),
        .mode_active  (mode_active),
        .scan_active  (scan_active)
    );

    always #5 clk_vga = ~clk_vga;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic set_px(input int r, input int g, input int b, input bit hb, input bit vb);
        r_in  = 6'(r);
        g_in  = 6'(g);
        b_in  = 6'(b);
        hb_in = hb;
        vb_in = vb;
    endtask

    task automatic check_px(input string tag, input int er, input int eg, input int eb);
        check({tag, ".r"}, int'(r_out), er);
        check({tag, ".g"}, int'(g_out), eg);
        check({tag, ".b"}, int'(b_out), eb);
    endtask

    // Hold an active pixel for three strobes so it reaches the outputs
    task automatic run_px(input string tag, input int r, input int g, input int b,
                          input int er, input int eg, input int eb);
        set_px(r, g, b, 1'b0, 1'b0);
        repeat (3) tick();
        check_px(tag, er, eg, eb);
    endtask

    task automatic vblank(input int mode, input bit scan);
        mode_req     = 2'(mode);
        scanline_req = scan;
        set_px(0, 0, 0, 1'b0, 1'b1);
        tick();
        vb_in = 1'b0;
    endtask

    task automatic strobe();
        ce_pix = 1'b1;
        tick();
        ce_pix = 1'b0;
        set_px(60, 60, 60, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        ce_pix = 1'b1;
        mode_req = 2'd0;
        scanline_req = 1'b0;
        hs_in = 1'b0;
        vs_in = 1'b0;
        set_px(0, 0, 0, 1'b0, 1'b0);
        repeat (2) tick();
        check_px("reset", 0, 0, 0);
        check("reset.mode", int'(mode_active), 0);
        check("reset.scan", int'(scan_active), 0);
        check("reset.hs", int'(hs_out), 0);
        reset = 1'b0;

        // Latency: captured on the first edge, visible after the third
        set_px(10, 20, 30, 1'b0, 1'b0);
        hs_in = 1'b1;
        vs_in = 1'b1;
        tick();
        set_px(0, 0, 0, 1'b0, 1'b0);
        hs_in = 1'b0;
        vs_in = 1'b0;
        tick();
        check("lat2.r", int'(r_out), 0);
        check("lat2.hs", int'(hs_out), 0);
        tick();
        check_px("lat3", 10, 20, 30);
        check("lat3.hs", int'(hs_out), 1);
        check("lat3.vs", int'(vs_out), 1);
        tick();
        check("lat4.hs", int'(hs_out), 0);

        vblank(3, 1'b0);
        check("white.mode", int'(mode_active), 3);
        run_px("white_max", 63, 63, 63, 63, 63, 63);
        run_px("white_r", 63, 0, 0, 13, 13, 13);
        run_px("white_g", 0, 63, 0, 45, 45, 45);
        // 19*63 + 128 = 1325, >> 8 = 5
        run_px("white_b", 0, 0, 63, 5, 5, 5);

        vblank(2, 1'b0);
        run_px("amber_g", 0, 63, 0, 45, 22, 0);
        vblank(1, 1'b0);
        run_px("green_max", 63, 63, 63, 0, 63, 0);

        // Request ignored until the next vblank edge
        vblank(0, 1'b0);
        mode_req = 2'd3;
        run_px("nochg", 63, 0, 0, 63, 0, 0);
        check("nochg.mode", int'(mode_active), 0);
        vblank(3, 1'b0);
        check("chg.mode", int'(mode_active), 3);
        run_px("chg", 63, 0, 0, 13, 13, 13);

        // Scanlines: even line, hblank pixel, odd line, even line
        vblank(3, 1'b1);
        check("scan.on", int'(scan_active), 1);
        run_px("line0", 0, 63, 0, 45, 45, 45);
        set_px(0, 63, 0, 1'b1, 1'b0);
        tick();
        set_px(0, 63, 0, 1'b0, 1'b0);
        repeat (2) tick();
        check_px("hblank", 0, 0, 0);
        check("hblank.hb", int'(hb_out), 1);
        run_px("line1", 0, 63, 0, 22, 22, 22);
        set_px(0, 63, 0, 1'b1, 1'b0);
        tick();
        run_px("line2", 0, 63, 0, 45, 45, 45);

        // ce_pix every 4th clock
        vblank(0, 1'b0);
        run_px("fill", 0, 63, 0, 0, 63, 0);
        set_px(7, 8, 9, 1'b0, 1'b0);
        strobe();
        set_px(1, 1, 1, 1'b0, 1'b0);
        strobe();
        check_px("ce2", 0, 63, 0);
        set_px(2, 2, 2, 1'b0, 1'b0);
        ce_pix = 1'b1;
        tick();
        check_px("ce3", 7, 8, 9);
        ce_pix = 1'b0;
        set_px(60, 60, 60, 1'b0, 1'b0);
        repeat (3) tick();
        check_px("ce_hold", 7, 8, 9);

        vblank(3, 1'b1);
        reset = 1'b1;
        tick();
        check_px("midrst", 0, 0, 0);
        check("midrst.mode", int'(mode_active), 0);
        check("midrst.scan", int'(scan_active), 0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
